// File: rtl/bridge_pkg.sv
// Shared definitions for the multi-channel DRAM bridge.
//   stateT    : bridge FSM states
//   axiRespT  : AXI4-Lite response codes
//   calcAddr  : index-to-byte-address mapping (caller truncates to ADDR_W)
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5
    } stateT;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axiRespT;

    localparam int CALC_W = 64;

    // Each index addresses one DATA_W-wide word, so the index is scaled by
    // the word size in bytes (byteShift = log2(DATA_W/8)).
    function automatic logic [CALC_W-1:0] calcAddr(
        input logic [CALC_W-1:0] base,
        input logic [CALC_W-1:0] idx,
        input int                byteShift
    );
        return base + (idx << byteShift);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the bridge channels.
//   clk, rst  : clock, synchronous active-high reset (pointer back to 0)
//   en        : a grant taken this cycle advances the pointer
//   req       : per-channel request vector
//   grant     : one-hot winner (zero when no request)
//   grantIdx  : binary index of the winner
// The search starts at the pointer; after a grant the pointer moves to
// winner+1 so the winner has lowest priority next time.
module rr_arbiter #(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grantIdx
);

    logic [CH_W-1:0] ptr;
    logic            found;
    int              cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = CH_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (int'(grantIdx) == N_CH - 1) ? '0 : grantIdx + CH_W'(1);
        end
    end

endmodule

// File: rtl/bridge_mc.sv
// Multi-channel DRAM bridge: N_CH clients share one AXI4-Lite master.
//   clk, rst          : clock, synchronous active-high reset
//   c_in_valid/c_ready: per-channel request handshake (c_ready = slot free)
//   c_r_wb, c_idx,
//   c_data_w          : per-channel request fields (1 = read)
//   c_out_valid       : one-cycle completion pulse to the owning channel
//   c_data_r, c_err   : shared read data / error flag, valid with c_out_valid
//   ar_*, r_*         : AXI4-Lite read address / read data channels
//   aw_*, w_*, b_*    : AXI4-Lite write address / write data / response
// Exactly one AXI transaction is outstanding at any time.
module bridge_mc
    import bridge_pkg::*;
#(
    parameter int                N_CH      = 2,
    parameter int                IDX_W     = 8,
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 17'h10000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          c_in_valid,
    output logic [N_CH-1:0]          c_ready,
    input  logic [N_CH-1:0]          c_r_wb,
    input  logic [N_CH*IDX_W-1:0]    c_idx,
    input  logic [N_CH*DATA_W-1:0]   c_data_w,
    output logic [N_CH-1:0]          c_out_valid,
    output logic [DATA_W-1:0]        c_data_r,
    output logic                     c_err,
    output logic                     ar_valid,
    input  logic                     ar_ready,
    output logic [ADDR_W-1:0]        ar_addr,
    input  logic                     r_valid,
    output logic                     r_ready,
    input  logic [DATA_W-1:0]        r_data,
    input  logic [1:0]               r_resp,
    output logic                     aw_valid,
    input  logic                     aw_ready,
    output logic [ADDR_W-1:0]        aw_addr,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [DATA_W-1:0]        w_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [1:0]               b_resp
);

    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    stateT              state;
    stateT              stateNext;

    logic [N_CH-1:0]    pend;
    logic [N_CH-1:0]    holdRwb;
    logic [IDX_W-1:0]   holdIdx  [N_CH];
    logic [DATA_W-1:0]  holdData [N_CH];

    logic [N_CH-1:0]    accept;
    logic [N_CH-1:0]    arbReq;
    logic [N_CH-1:0]    grantOh;
    logic [CH_W-1:0]    grantIdx;
    logic               arbEn;
    logic               grantLoad;

    logic               effRwb;
    logic [IDX_W-1:0]   effIdx;
    logic [DATA_W-1:0]  effData;

    logic [N_CH-1:0]    curOh;
    logic               curRead;
    logic               awDone;
    logic               wDone;
    logic [N_CH-1:0]    doneClr;

    logic [ADDR_W-1:0]  addrQ;
    logic [DATA_W-1:0]  wDataQ;
    logic [DATA_W-1:0]  rDataQ;
    axiRespT            respQ;

    // A slot is free exactly when nothing is pending on it; because pend
    // only clears at the end of DONE, a request presented during the
    // completion cycle is refused and c_ready rises one cycle later.
    assign c_ready = ~pend;
    assign accept  = c_in_valid & ~pend;

    // A request arriving while the FSM idles competes immediately, so the
    // AXI address phase starts the cycle after acceptance.
    assign arbReq    = pend | accept;
    assign arbEn     = (state == IDLE);
    assign grantLoad = arbEn && (|arbReq);

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) uArb (
        .clk      (clk),
        .rst      (rst),
        .en       (arbEn),
        .req      (arbReq),
        .grant    (grantOh),
        .grantIdx (grantIdx)
    );

    // Winner's request fields: from the holding register when it was
    // accepted earlier, straight from the ports when accepted this cycle.
    always_comb begin
        effRwb  = c_r_wb[grantIdx];
        effIdx  = c_idx[grantIdx*IDX_W +: IDX_W];
        effData = c_data_w[grantIdx*DATA_W +: DATA_W];
        if (pend[grantIdx]) begin
            effRwb  = holdRwb[grantIdx];
            effIdx  = holdIdx[grantIdx];
            effData = holdData[grantIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (|arbReq) begin
                    stateNext = effRwb ? RD_A : WR_AW;
                end
            end
            RD_A: begin
                if (ar_ready) begin
                    stateNext = RD_D;
                end
            end
            RD_D: begin
                if (r_valid) begin
                    stateNext = DONE;
                end
            end
            WR_AW: begin
                // Each half is finished if it already handshook or does so now.
                if ((awDone || aw_ready) && (wDone || w_ready)) begin
                    stateNext = WR_B;
                end
            end
            WR_B: begin
                if (b_valid) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign doneClr = (state == DONE) ? curOh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            curOh   <= '0;
            curRead <= 1'b0;
            awDone  <= 1'b0;
            wDone   <= 1'b0;
        end else begin
            pend <= (pend & ~doneClr) | accept;
            if (grantLoad) begin
                curOh   <= grantOh;
                curRead <= effRwb;
                awDone  <= 1'b0;
                wDone   <= 1'b0;
            end else begin
                if (aw_valid && aw_ready) begin
                    awDone <= 1'b1;
                end
                if (w_valid && w_ready) begin
                    wDone <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addrQ  <= '0;
            wDataQ <= '0;
        end else if (grantLoad) begin
            addrQ  <= ADDR_W'(calcAddr(CALC_W'(ADDR_BASE), CALC_W'(effIdx), BYTE_SHIFT));
            wDataQ <= effRwb ? '0 : effData;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (accept[i]) begin
                holdRwb[i]  <= c_r_wb[i];
                holdIdx[i]  <= c_idx[i*IDX_W +: IDX_W];
                holdData[i] <= c_data_w[i*DATA_W +: DATA_W];
            end
        end
        if (state == RD_D && r_valid) begin
            rDataQ <= r_data;
            respQ  <= axiRespT'(r_resp);
        end
        if (state == WR_B && b_valid) begin
            respQ <= axiRespT'(b_resp);
        end
    end

    assign ar_valid = (state == RD_A);
    assign r_ready  = (state == RD_D);
    assign aw_valid = (state == WR_AW) && !awDone;
    assign w_valid  = (state == WR_AW) && !wDone;
    assign b_ready  = (state == WR_B);
    assign ar_addr  = addrQ;
    assign aw_addr  = addrQ;
    assign w_data   = wDataQ;

    assign c_out_valid = doneClr;
    assign c_data_r    = (state == DONE && curRead) ? rDataQ : '0;
    assign c_err       = (state == DONE) && (respQ != OKAY);

endmodule

// File: tb/tb_bridge_mc.sv
module tb_bridge_mc;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    c_in_valid;
    logic [1:0]    c_ready;
    logic [1:0]    c_r_wb;
    logic [15:0]   c_idx;
    logic [127:0]  c_data_w;
    logic [1:0]    c_out_valid;
    logic [63:0]   c_data_r;
    logic          c_err;
    logic          ar_valid;
    logic          ar_ready;
    logic [16:0]   ar_addr;
    logic          r_valid;
    logic          r_ready;
    logic [63:0]   r_data;
    logic [1:0]    r_resp;
    logic          aw_valid;
    logic          aw_ready;
    logic [16:0]   aw_addr;
    logic          w_valid;
    logic          w_ready;
    logic [63:0]   w_data;
    logic          b_valid;
    logic          b_ready;
    logic [1:0]    b_resp;

    int checks   = 0;
    int failures = 0;

    int         awWait = 0;
    int         wWait  = 0;
    int         arWait = 0;
    logic [1:0] rResp  = 2'b00;
    logic [1:0] bResp  = 2'b00;
    logic       rNever = 1'b0;

    logic [63:0] mem [logic [16:0]];

    always #5 clk = ~clk;

    bridge_mc #(
        .N_CH      (2),
        .IDX_W     (8),
        .DATA_W    (64),
        .ADDR_W    (17),
        .ADDR_BASE (17'h10000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_in_valid  (c_in_valid),
        .c_ready     (c_ready),
        .c_r_wb      (c_r_wb),
        .c_idx       (c_idx),
        .c_data_w    (c_data_w),
        .c_out_valid (c_out_valid),
        .c_data_r    (c_data_r),
        .c_err       (c_err),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .aw_valid    (aw_valid),
        .aw_ready    (aw_ready),
        .aw_addr     (aw_addr),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_resp      (b_resp)
    );

    // AXI4-Lite slave with a small memory; drives its signals mid-cycle.
    initial begin : slave
        int          arCnt;
        int          awCnt;
        int          wCnt;
        logic        rdPend;
        logic        awGot;
        logic        wGot;
        logic        arHs;
        logic        awHs;
        logic        wHs;
        logic        rHs;
        logic        bHs;
        logic [16:0] arAddrCap;
        logic [16:0] awAddrCap;
        logic [63:0] wDataCap;
        arCnt = 0; awCnt = 0; wCnt = 0;
        rdPend = 1'b0; awGot = 1'b0; wGot = 1'b0;
        arHs = 1'b0; awHs = 1'b0; wHs = 1'b0; rHs = 1'b0; bHs = 1'b0;
        arAddrCap = '0; awAddrCap = '0; wDataCap = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
        b_valid = 1'b0; b_resp = 2'b00;
        forever begin
            @(negedge clk);
            if (arHs) rdPend = 1'b1;
            if (rHs) rdPend = 1'b0;
            if (awHs) awGot = 1'b1;
            if (wHs) wGot = 1'b1;
            if (bHs) begin
                mem[awAddrCap] = wDataCap;
                awGot = 1'b0;
                wGot  = 1'b0;
            end
            if (rst) begin
                arCnt = 0; awCnt = 0; wCnt = 0;
                rdPend = 1'b0; awGot = 1'b0; wGot = 1'b0;
                arHs = 1'b0; awHs = 1'b0; wHs = 1'b0; rHs = 1'b0; bHs = 1'b0;
                ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
                r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
                b_valid = 1'b0; b_resp = 2'b00;
            end else begin
                ar_ready = ar_valid && (arCnt >= arWait);
                arCnt    = ar_valid ? arCnt + 1 : 0;
                aw_ready = aw_valid && (awCnt >= awWait);
                awCnt    = aw_valid ? awCnt + 1 : 0;
                w_ready  = w_valid && (wCnt >= wWait);
                wCnt     = w_valid ? wCnt + 1 : 0;
                r_valid  = rdPend && !rNever;
                r_data   = (r_valid && mem.exists(arAddrCap)) ? mem[arAddrCap] : 64'h0;
                r_resp   = r_valid ? rResp : 2'b00;
                b_valid  = awGot && wGot;
                b_resp   = b_valid ? bResp : 2'b00;
                arHs = ar_valid && ar_ready;
                if (arHs) arAddrCap = ar_addr;
                awHs = aw_valid && aw_ready;
                if (awHs) awAddrCap = aw_addr;
                wHs = w_valid && w_ready;
                if (wHs) wDataCap = w_data;
                rHs = r_valid && r_ready;
                bHs = b_valid && b_ready;
            end
        end
    end

    task automatic sendReq(input int ch, input logic rwb, input logic [7:0] idx, input logic [63:0] d);
        @(posedge clk); #1;
        c_in_valid[ch]          = 1'b1;
        c_r_wb[ch]              = rwb;
        c_idx[ch*8 +: 8]        = idx;
        c_data_w[ch*64 +: 64]   = d;
        @(posedge clk); #1;
        c_in_valid[ch] = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output int n, output logic [1:0] ov,
                            output logic [63:0] d, output logic e);
        n = maxCyc + 1; ov = '0; d = '0; e = 1'b0;
        for (int i = 1; i <= maxCyc; i++) begin
            @(negedge clk);
            if (c_out_valid != 2'b00) begin
                n = i; ov = c_out_valid; d = c_data_r; e = c_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; c_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (c_ready !== 2'b11) begin
            failures++; $display("FAIL reset_c_ready got=%b want=11", c_ready);
        end
        checks++;
        if ({c_out_valid, c_err} !== 3'b000) begin
            failures++; $display("FAIL reset_out got=%b want=000", {c_out_valid, c_err});
        end
        checks++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready} !== 5'b00000) begin
            failures++; $display("FAIL reset_axi_ctl got=%b want=00000", {ar_valid, aw_valid, w_valid, r_ready, b_ready});
        end
        checks++;
        if (ar_addr !== 17'h0 || aw_addr !== 17'h0 || w_data !== 64'h0 || c_data_r !== 64'h0) begin
            failures++; $display("FAIL reset_data got ar=%h aw=%h w=%h r=%h want all 0", ar_addr, aw_addr, w_data, c_data_r);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_basic();
        int n; logic [1:0] ov; logic [63:0] d; logic e;
        rResp = 2'b00;
        sendReq(0, 1'b1, 8'h05, 64'h0);
        @(negedge clk);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 17'h10028) begin
            failures++; $display("FAIL rd_ar got valid=%b addr=%h want valid=1 addr=10028", ar_valid, ar_addr);
        end
        checks++;
        if (c_ready !== 2'b10) begin
            failures++; $display("FAIL rd_busy got=%b want=10", c_ready);
        end
        waitDone(10, n, ov, d, e);
        checks++;
        if (n !== 2) begin
            failures++; $display("FAIL rd_latency got=t+%0d want=t+3", n + 1);
        end
        checks++;
        if (ov !== 2'b01 || d !== 64'hDEAD_BEEF_0123_4567 || e !== 1'b0) begin
            failures++; $display("FAIL rd_result got ov=%b data=%h err=%b want ov=01 data=deadbeef01234567 err=0", ov, d, e);
        end
    endtask

    task automatic test_write_wait();
        int awCyc; int wCyc; logic okAw; logic okW;
        int n; logic [1:0] ov; logic [63:0] d; logic e;
        awWait = 3; wWait = 0; bResp = 2'b00;
        awCyc = 0; wCyc = 0; okAw = 1'b1; okW = 1'b1;
        n = 99; ov = '0; d = '0; e = 1'b0;
        sendReq(1, 1'b0, 8'hFF, 64'hA5A5_0000_1111_2222);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (aw_valid) begin
                awCyc++;
                if (aw_addr !== 17'h107F8) okAw = 1'b0;
            end
            if (w_valid) begin
                wCyc++;
                if (w_data !== 64'hA5A5_0000_1111_2222) okW = 1'b0;
            end
            if (c_out_valid != 2'b00) begin
                n = i; ov = c_out_valid; d = c_data_r; e = c_err;
                break;
            end
        end
        checks++;
        if (awCyc !== 4 || wCyc !== 1) begin
            failures++; $display("FAIL wr_valid_len got aw=%0d w=%0d want aw=4 w=1", awCyc, wCyc);
        end
        checks++;
        if ({okAw, okW} !== 2'b11) begin
            failures++; $display("FAIL wr_stable got addr_ok=%b data_ok=%b want 1 1", okAw, okW);
        end
        checks++;
        if (n !== 6) begin
            failures++; $display("FAIL wr_latency got=t+%0d want=t+6", n);
        end
        checks++;
        if (ov !== 2'b10 || e !== 1'b0 || d !== 64'h0) begin
            failures++; $display("FAIL wr_result got ov=%b err=%b data=%h want ov=10 err=0 data=0", ov, e, d);
        end
        awWait = 0;
    endtask

    task automatic test_error_busy();
        int n; logic [1:0] ov; logic e; int extra;
        n = 99; ov = '0; e = 1'b0;
        rResp = 2'b10;
        @(posedge clk); #1;
        c_in_valid[0] = 1'b1; c_r_wb[0] = 1'b1; c_idx[7:0] = 8'h03;
        @(posedge clk); #1;
        c_idx[7:0] = 8'h09;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (c_ready[0] !== 1'b0 || ar_addr !== 17'h10018) begin
                    failures++; $display("FAIL busy_refuse got ready0=%b addr=%h want ready0=0 addr=10018", c_ready[0], ar_addr);
                end
            end
            if (c_out_valid != 2'b00) begin
                n = i; ov = c_out_valid; e = c_err;
                break;
            end
        end
        checks++;
        if (n !== 3 || ov !== 2'b01 || e !== 1'b1) begin
            failures++; $display("FAIL err_result got n=%0d ov=%b err=%b want n=3 ov=01 err=1", n, ov, e);
        end
        @(posedge clk); #1;
        c_in_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (c_ready !== 2'b11 || ar_valid !== 1'b0) begin
            failures++; $display("FAIL done_refuse got ready=%b ar_valid=%b want ready=11 ar_valid=0", c_ready, ar_valid);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c_out_valid != 2'b00 || ar_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++; $display("FAIL busy_no_extra got=%0d want=0", extra);
        end
        rResp = 2'b00;
    endtask

    task automatic test_arbitration();
        int n; logic [1:0] ov; logic [63:0] d; logic e;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // ch0 writes idx 0x20 while ch1 reads idx 0x20 in the same cycle
        @(posedge clk); #1;
        c_in_valid = 2'b11; c_r_wb = 2'b10;
        c_idx = {8'h20, 8'h20};
        c_data_w = {64'h0, 64'hCAFE_F00D_5555_AAAA};
        @(posedge clk); #1;
        c_in_valid = 2'b00;
        waitDone(10, n, ov, d, e);
        checks++;
        if (n !== 3 || ov !== 2'b01 || d !== 64'h0) begin
            failures++; $display("FAIL arb_first got n=%0d ov=%b data=%h want n=3 ov=01 data=0", n, ov, d);
        end
        waitDone(10, n, ov, d, e);
        checks++;
        if (n !== 4 || ov !== 2'b10 || d !== 64'hCAFE_F00D_5555_AAAA) begin
            failures++; $display("FAIL arb_second got n=%0d ov=%b data=%h want n=4 ov=10 data=cafef00d5555aaaa", n, ov, d);
        end
        // a lone ch0 grant leaves the pointer on ch1
        sendReq(0, 1'b1, 8'h05, 64'h0);
        waitDone(10, n, ov, d, e);
        checks++;
        if (ov !== 2'b01 || d !== 64'hDEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL arb_single got ov=%b data=%h want ov=01 data=deadbeef01234567", ov, d);
        end
        @(posedge clk); #1;
        c_in_valid = 2'b11; c_r_wb = 2'b11;
        c_idx = {8'h20, 8'h05};
        @(posedge clk); #1;
        c_in_valid = 2'b00;
        waitDone(10, n, ov, d, e);
        checks++;
        if (ov !== 2'b10 || d !== 64'hCAFE_F00D_5555_AAAA) begin
            failures++; $display("FAIL arb_rotate_first got ov=%b data=%h want ov=10 data=cafef00d5555aaaa", ov, d);
        end
        waitDone(10, n, ov, d, e);
        checks++;
        if (ov !== 2'b01 || d !== 64'hDEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL arb_rotate_second got ov=%b data=%h want ov=01 data=deadbeef01234567", ov, d);
        end
    endtask

    task automatic test_reset_mid();
        logic seen; int extra;
        rNever = 1'b1;
        seen = 1'b0;
        sendReq(1, 1'b1, 8'h10, 64'h0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (r_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++; $display("FAIL rstmid_reach_rd_d got=%b want=1", seen);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready} !== 5'b00000 || c_ready !== 2'b11 || c_out_valid !== 2'b00) begin
            failures++; $display("FAIL rstmid_clear got ctl=%b ready=%b ov=%b want ctl=00000 ready=11 ov=00",
                                 {ar_valid, aw_valid, w_valid, r_ready, b_ready}, c_ready, c_out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0; rNever = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (c_out_valid != 2'b00 || ar_valid || aw_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++; $display("FAIL rstmid_no_report got=%0d want=0", extra);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b1;
        c_in_valid = '0;
        c_r_wb = '0;
        c_idx = '0;
        c_data_w = '0;
        mem[17'h10028] = 64'hDEAD_BEEF_0123_4567;
        repeat (2) @(posedge clk);
        test_reset();
        test_read_basic();
        test_write_wait();
        test_error_busy();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
